// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 halfword rotate/shift controller:
// opcode constants, operation select and the per-stage pipeline record.
package fx2_pkg;

  // SPU RR/RI7 opcodes, big-endian bit order [0:10]
  localparam logic [0:10] OPC_ROTH  = 11'b00001011100;
  localparam logic [0:10] OPC_ROTHI = 11'b00001111100;
  localparam logic [0:10] OPC_SHLH  = 11'b00001011111;
  localparam logic [0:10] OPC_SHLHI = 11'b00001111111;

  typedef enum logic [2:0] {
    OP_ROTH,
    OP_ROTHI,
    OP_SHLH,
    OP_SHLHI,
    OP_ILL
  } op_sel_e;

  typedef struct packed {
    logic         valid;
    logic [6:0]   rt;
    logic [0:127] data;
  } stage_t;

  function automatic op_sel_e decode_op(input logic [0:10] op);
    case (op)
      OPC_ROTH:  return OP_ROTH;
      OPC_ROTHI: return OP_ROTHI;
      OPC_SHLH:  return OP_SHLH;
      OPC_SHLHI: return OP_SHLHI;
      default:   return OP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/fx2_hw_shift.sv
// Combinational datapath: per-halfword rotate-left or zero-filling shift-left
// across the eight halfwords of a 128-bit operand.
module fx2_hw_shift
  import fx2_pkg::*;
(
  input  op_sel_e      sel,
  input  logic [0:127] ra,
  input  logic [0:127] rb,
  input  logic [0:6]   imm7,
  output logic [0:127] res
);

  // Doubling the halfword makes the upper half of the shifted value the
  // rotate result and the lower half the zero-filled shift result.
  function automatic logic [15:0] hw_op(input op_sel_e s, input logic [15:0] a,
                                        input logic [4:0] b_amt, input logic [4:0] i_amt);
    logic [4:0]  n;
    logic [31:0] dbl;
    case (s)
      OP_ROTH:  n = {1'b0, b_amt[3:0]};
      OP_ROTHI: n = {1'b0, i_amt[3:0]};
      OP_SHLH:  n = b_amt;
      OP_SHLHI: n = i_amt;
      default:  n = 5'd0;
    endcase
    dbl = {a, a} << n[3:0];
    case (s)
      OP_ROTH, OP_ROTHI: return dbl[31:16];
      OP_SHLH, OP_SHLHI: return n[4] ? 16'h0000 : dbl[15:0];
      default:           return 16'h0000;
    endcase
  endfunction

  // Only the low-order amount bits of rb halfwords and imm7 matter.
  logic unused_bits;
  assign unused_bits = ^{imm7[0:1], rb};

  // Apply the selected operation to each halfword independently.
  always_comb begin
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[16*i +: 16] = hw_op(sel, ra[16*i +: 16], rb[16*i+11 +: 5], imm7[2:6]);
    end
  end

endmodule

// File: rtl/fx2_ctrl.sv
// FX2 issue/writeback controller: decodes halfword rotate/shift ops, computes
// them in stage 1 and carries the result to writeback through LAT stages with
// writeback stall, bubble collapse, flush and a register hazard query.
module fx2_ctrl
  import fx2_pkg::*;
#(
  parameter int LAT = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic [0:10]  issue_op,
  input  logic [6:0]   issue_rt,
  input  logic [0:127] issue_ra,
  input  logic [0:127] issue_rb,
  input  logic [0:6]   issue_imm7,
  input  logic         flush,
  input  logic         wb_stall,
  output logic         wb_valid,
  output logic [6:0]   wb_rt,
  output logic [0:127] wb_data,
  output logic         illegal_op,
  input  logic [6:0]   query_rt,
  output logic         query_hit,
  output logic         busy
);

  op_sel_e      sel;
  logic [0:127] result;
  logic         adv;
  logic         accept;
  stage_t       stg [1:LAT];

  assign sel = decode_op(issue_op);

  fx2_hw_shift u_shift (
    .sel  (sel),
    .ra   (issue_ra),
    .rb   (issue_rb),
    .imm7 (issue_imm7),
    .res  (result)
  );

  // The whole pipe moves together unless a held writeback blocks the tail;
  // an empty tail lets younger entries slide forward even under stall.
  assign adv         = !wb_stall || !stg[LAT].valid;
  assign issue_ready = adv && !flush;
  assign accept      = issue_valid && issue_ready;

  // Stage registers and the illegal-opcode pulse; flush beats issue and stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) stg[k] <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && (sel == OP_ILL);
      if (flush) begin
        for (int k = 1; k <= LAT; k++) stg[k].valid <= 1'b0;
      end else if (adv) begin
        stg[1].valid <= accept && (sel != OP_ILL);
        stg[1].rt    <= issue_rt;
        stg[1].data  <= result;
        for (int k = 2; k <= LAT; k++) stg[k] <= stg[k-1];
      end
    end
  end

  assign wb_valid = stg[LAT].valid;
  assign wb_rt    = wb_valid ? stg[LAT].rt   : '0;
  assign wb_data  = wb_valid ? stg[LAT].data : '0;

  // Hazard query and busy look only at valid stages.
  always_comb begin
    query_hit = 1'b0;
    busy      = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      busy = busy | stg[k].valid;
      if (stg[k].valid && (stg[k].rt == query_rt)) query_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_ctrl.sv
// Scoreboard bench for fx2_ctrl: accepted instructions push expected results
// from an arithmetic reference model; a monitor checks writebacks, timing,
// stall hold, flush, illegal pulses, busy and the hazard query.
module tb_fx2_ctrl;
  import fx2_pkg::*;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue_valid;
  logic         issue_ready;
  logic [0:10]  issue_op;
  logic [6:0]   issue_rt;
  logic [0:127] issue_ra;
  logic [0:127] issue_rb;
  logic [0:6]   issue_imm7;
  logic         flush;
  logic         wb_stall;
  logic         wb_valid;
  logic [6:0]   wb_rt;
  logic [0:127] wb_data;
  logic         illegal_op;
  logic [6:0]   query_rt;
  logic         query_hit;
  logic         busy;

  always #5 clk = ~clk;

  fx2_ctrl #(.LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_rt    (issue_rt),
    .issue_ra    (issue_ra),
    .issue_rb    (issue_rb),
    .issue_imm7  (issue_imm7),
    .flush       (flush),
    .wb_stall    (wb_stall),
    .wb_valid    (wb_valid),
    .wb_rt       (wb_rt),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op),
    .query_rt    (query_rt),
    .query_hit   (query_hit),
    .busy        (busy)
  );

  typedef struct {
    logic [6:0]   rt;
    logic [0:127] data;
    int           acc;
    int           frz;
  } exp_t;

  exp_t exp_q[$];
  int   ill_q[$];
  int   cyc    = 0;
  int   frozen = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_legal(input logic [0:10] op);
    return (op == OPC_ROTH) || (op == OPC_ROTHI) || (op == OPC_SHLH) || (op == OPC_SHLHI);
  endfunction

  // Reference: each halfword as an integer, rotate/shift by multiplication.
  function automatic logic [0:127] ref_model(input logic [0:10] op, input logic [0:127] ra,
                                             input logic [0:127] rb, input logic [0:6] imm);
    logic [0:127] r;
    r = '0;
    for (int h = 0; h < 8; h++) begin
      int unsigned a, b, n, v;
      a = int'(ra[16*h +: 16]);
      b = int'(rb[16*h +: 16]);
      if (op == OPC_ROTH)       n = b % 16;
      else if (op == OPC_ROTHI) n = int'(imm) % 16;
      else if (op == OPC_SHLH)  n = b % 32;
      else                      n = int'(imm) % 32;
      if (op == OPC_ROTH || op == OPC_ROTHI)
        v = (a * (1 << n) + a / (1 << (16 - n))) % 65536;
      else
        v = (n >= 16) ? 0 : (a * (1 << n)) % 65536;
      r[16*h +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Issue side of the scoreboard: record every accepted instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && issue_valid && issue_ready === 1'b1) begin
      if (is_legal(issue_op))
        exp_q.push_back('{issue_rt, ref_model(issue_op, issue_ra, issue_rb, issue_imm7), cyc, frozen});
      else
        ill_q.push_back(cyc);
    end
  end

  // Monitor: compare DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    bit   busy_exp, hit_exp, ill_exp;
    exp_t e;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      ill_q.delete();
    end else begin
      busy_exp = 1'b0;
      hit_exp  = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i].acc < cyc) begin
          busy_exp = 1'b1;
          if (exp_q[i].rt == query_rt) hit_exp = 1'b1;
        end
      end
      chk("issue_ready", issue_ready, (!wb_stall || !wb_valid) && !flush);
      chk("busy", busy, busy_exp);
      chk("query_hit", query_hit, hit_exp);
      ill_exp = (ill_q.size() > 0) && (ill_q[0] == cyc - 1);
      if (ill_exp) void'(ill_q.pop_front());
      chk("illegal_op", illegal_op, ill_exp);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].acc >= cyc) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got rt %0d data %h expected no writeback (cycle %0d)", wb_rt, wb_data, cyc);
        end else begin
          chk("wb_rt", wb_rt, exp_q[0].rt);
          chk("wb_data", wb_data, exp_q[0].data);
          if (!wb_stall) begin
            e = exp_q.pop_front();
            chk("wb_cycle", cyc, e.acc + LAT + (frozen - e.frz));
          end else begin
            frozen++;
          end
        end
      end else begin
        chk("wb_valid", wb_valid, 1'b0);
        chk("wb_rt_idle", wb_rt, 0);
        chk("wb_data_idle", wb_data, 0);
        if (exp_q.size() > 0 && exp_q[0].acc < cyc) begin
          checks++;
          if (cyc > exp_q[0].acc + LAT + (frozen - exp_q[0].frz)) begin
            errors++;
            $display("FAIL wb_overdue: got no writeback expected rt %0d by cycle %0d (cycle %0d)",
                     exp_q[0].rt, exp_q[0].acc + LAT + (frozen - exp_q[0].frz), cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive(input logic [0:10] op, input logic [6:0] rt, input logic [0:127] ra,
                       input logic [0:127] rb, input logic [0:6] imm);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rt    = rt;
    issue_ra    = ra;
    issue_rb    = rb;
    issue_imm7  = imm;
    step();
    issue_valid = 1'b0;
  endtask

  function automatic logic [0:127] rep(input logic [15:0] h);
    return {8{h}};
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int          r;
    logic [0:10] op;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_rt    = '0;
    issue_ra    = '0;
    issue_rb    = '0;
    issue_imm7  = '0;
    flush       = 1'b0;
    wb_stall    = 1'b0;
    query_rt    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_illegal", illegal_op, 1'b0);
    chk("reset_ready", issue_ready, 1'b1);
    step();

    // rotate 0x8001 left by one -> 0x0003
    drive(OPC_ROTHI, 7'd9, rep(16'h8001), rnd128(), 7'd1);
    idle(6);

    // shift by 16 clears, shift by 4 gives 0xFFF0
    drive(OPC_SHLH, 7'd10, rep(16'hFFFF), rep(16'h0010), 7'd0);
    drive(OPC_SHLH, 7'd11, rep(16'hFFFF), rep(16'h0004), 7'd0);
    idle(6);

    // back-to-back rt 1..4, then hold the first writeback for 3 cycles
    for (int i = 1; i <= 4; i++) drive(OPC_ROTH, 7'(i), rnd128(), rnd128(), 7'(i));
    for (int i = 0; i < 10 && wb_valid !== 1'b1; i++) step();
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_setup: got wb_valid %b expected 1 within 10 cycles", wb_valid);
    end
    wb_stall    = 1'b1;
    issue_valid = 1'b1;
    issue_op    = OPC_SHLHI;
    issue_rt    = 7'd12;
    issue_ra    = rnd128();
    issue_imm7  = 7'd3;
    repeat (3) step();
    wb_stall = 1'b0;
    step();
    idle(8);

    // flush two cycles after issuing rt=5
    query_rt = 7'd5;
    drive(OPC_SHLHI, 7'd5, rnd128(), rnd128(), 7'd2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(6);

    // unsupported opcodes
    drive(11'h000, 7'd7, rnd128(), rnd128(), 7'd0);
    idle(3);
    drive(11'h7FF, 7'd8, rnd128(), rnd128(), 7'd0);
    idle(6);

    // reset while instructions are in flight
    for (int i = 0; i < 3; i++) drive(OPC_SHLHI, 7'(20 + i), rnd128(), rnd128(), 7'(i));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(8);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      case (r % 4)
        0:       op = OPC_ROTH;
        1:       op = OPC_ROTHI;
        2:       op = OPC_SHLH;
        default: op = OPC_SHLHI;
      endcase
      if (r == 9) op = 11'($urandom());
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_op    = op;
      issue_rt    = 7'($urandom_range(0, 7));
      issue_ra    = rnd128();
      issue_rb    = rnd128();
      issue_imm7  = 7'($urandom());
      wb_stall    = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 99) < 3);
      query_rt    = 7'($urandom_range(0, 7));
      step();
    end

    // drain
    issue_valid = 1'b0;
    wb_stall    = 1'b0;
    flush       = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending writebacks expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx2_ctrl.md
FX2_CTRL -- requirements
Module: fx2_ctrl

Interface
REQ-001 Parameter: LAT, default 4, number of pipeline stages from issue to writeback (legal range 2..6).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous reset, active-low.
REQ-004 issue_valid  in  1  instruction presented this cycle.
REQ-005 issue_ready  out  1  controller accepts the instruction this cycle.
REQ-006 issue_op  in  11  SPU opcode, big-endian [0:10].
REQ-007 issue_rt  in  7  destination register address.
REQ-008 issue_ra  in  128  operand A, [0:127].
REQ-009 issue_rb  in  128  operand B, [0:127].
REQ-010 issue_imm7  in  7  immediate, [0:6].
REQ-011 flush  in  1  kill every in-flight instruction.
REQ-012 wb_stall  in  1  register file cannot accept a writeback.
REQ-013 wb_valid  out  1  writeback valid.
REQ-014 wb_rt  out  7  writeback register address.
REQ-015 wb_data  out  128  writeback data.
REQ-016 illegal_op  out  1  one-cycle pulse: an unsupported opcode was offered.
REQ-017 query_rt  in  7  register address for a hazard query.
REQ-018 query_hit  out  1  combinational; some valid in-flight stage targets query_rt.
REQ-019 busy  out  1  OR of all stage valid bits.

Function
REQ-020 The supported operations shall be ROTH, ROTHI, SHLH and SHLHI; the opcode encodings are fixed in the package.
REQ-021 ROTH and ROTHI shall rotate each of the 8 halfwords left by n bits; n = rb halfword bits [12:15] for ROTH and imm7[3:6] for ROTHI.
REQ-022 SHLH and SHLHI shall shift each halfword left, zero-filling; n = rb halfword bits [11:15] for SHLH and imm7[2:6] for SHLHI. A result of n>=16 shall be 0x0000.
REQ-023 Handshake: an instruction shall be accepted when issue_valid and issue_ready are both 1.
REQ-024 issue_ready shall equal (not wb_stall or stage LAT empty) and not flush.
REQ-025 A supported opcode, when accepted, shall be computed in stage 1 and carried with its rt through stages 2..LAT.
REQ-026 wb_valid shall rise exactly LAT cycles after acceptance when no stall intervenes.
REQ-027 An unsupported opcode offered with issue_ready=1 shall pulse illegal_op for one cycle the next cycle and shall not enter the pipeline.
REQ-028 When wb_valid=1 and wb_stall=1, all stages shall hold their contents and wb_valid/wb_rt/wb_data shall stay stable.
REQ-029 When wb_stall=1 and stage LAT is empty, younger stages shall advance to close bubbles.
REQ-030 flush shall clear all stage valid bits at the next edge and take priority over issue and stall; wb_valid shall be 0 in the cycle after flush.
REQ-031 query_hit shall ignore invalid stages; duplicate rt values in flight are legal.
REQ-032 wb_data and wb_rt shall be 0 whenever wb_valid=0.

Reset
REQ-033 At reset all stage valid bits, wb_valid, wb_rt, wb_data, illegal_op and busy shall be 0; issue_ready shall be 1 from the first cycle after reset.
REQ-034 Reset asserted mid-operation shall discard all in-flight instructions with no writeback.

Structure
REQ-035 Package fx2_pkg shall hold the opcode constants, the op-select enum (OP_ROTH, OP_ROTHI, OP_SHLH, OP_SHLHI, OP_ILL) and the per-stage record type (valid, rt, data).
REQ-036 One sub-module, fx2_hw_shift, shall hold the combinational halfword rotate/shift datapath; decode, staging, stall and flush logic stay in fx2_ctrl.

Verification
REQ-037 Reset, then ROTHI with ra=0x8001 in every halfword, imm7=1 -> after 4 cycles wb_valid=1, data=0x0003 in every halfword.
REQ-038 SHLH with ra halfwords 0xFFFF, rb halfwords 0x0010 -> result 0x0000 in every halfword; with rb=0x0004 -> result 0xFFF0.
REQ-039 Back-to-back issues on four consecutive cycles with rt=1,2,3,4 -> four consecutive wb_valid cycles in order.
REQ-040 Hold wb_stall=1 for 3 cycles while wb_valid=1 -> outputs stable, issue_ready=0, no loss; order preserved after release.
REQ-041 Issue rt=5, flush 2 cycles later -> no writeback, busy=0 next cycle, query_rt=5 then gives hit=0.
REQ-042 Opcode 0x000 offered -> illegal_op pulses once and no writeback occurs.
